// File: rtl/led_matrix_scan_if.sv
// led_matrix_scan_if: frame handshake between upstream frame source and the LED matrix scanner.
// master = frame source, slave = scanner.
interface led_matrix_scan_if;
  logic        frame_valid;
  logic [15:0] frame_data;
  logic        frame_ready;

  modport master (output frame_valid, output frame_data, input frame_ready);
  modport slave  (input frame_valid, input frame_data, output frame_ready);
endinterface

// File: rtl/led_matrix_scan.sv
// led_matrix_scan: 4x4 LED row scanner with double-buffered frames and inter-row blanking.
// Define LED_MATRIX_PWM_EN to add 16-slice global brightness PWM inside each row's ON phase.
module led_matrix_scan #(
  parameter int ROW_CYCLES   = 12000,
  parameter int BLANK_CYCLES = 48
) (
  input  logic             clk,
  input  logic             rst,
  led_matrix_scan_if.slave frm,
  input  logic [3:0]       brightness,
  output logic [3:0]       aled,
  output logic [3:0]       kled_oe,
  output logic             frame_start
);
  localparam int MAX_CYCLES = (ROW_CYCLES > BLANK_CYCLES) ? ROW_CYCLES : BLANK_CYCLES;
  localparam int PW = $clog2(MAX_CYCLES);
  localparam logic [PW-1:0] BLANK_LAST = PW'(BLANK_CYCLES - 1);
  localparam logic [PW-1:0] ROW_LAST   = PW'(ROW_CYCLES - 1);

  typedef enum logic {BLANK, ON} state_t;

  state_t         state, state_nxt;
  logic [PW-1:0]  phase, phase_nxt;
  logic [1:0]     row, row_nxt;
  logic [15:0]    front, front_nxt;
  logic [15:0]    back, back_nxt;
  logic           pending, pending_nxt;
  logic [3:0]     aled_nxt, kled_nxt;
  logic           frame_start_nxt;
  logic           accept;
  logic           lit;

`ifdef LED_MATRIX_PWM_EN
  localparam int SLICE_CYCLES = ROW_CYCLES / 16;
  logic [3:0] bright_lat, bright_nxt;
`else
  logic unused_brightness;
  assign unused_brightness = ^brightness;
`endif

  assign accept = frm.frame_valid && frm.frame_ready;

  always_comb begin
    state_nxt       = state;
    phase_nxt       = phase;
    row_nxt         = row;
    front_nxt       = front;
    back_nxt        = back;
    pending_nxt     = pending;
    aled_nxt        = 4'b0000;
    kled_nxt        = 4'b0000;
    frame_start_nxt = 1'b0;
    lit             = 1'b1;
`ifdef LED_MATRIX_PWM_EN
    bright_nxt      = bright_lat;
`endif

    case (state)
      BLANK: begin
        if (phase == BLANK_LAST) begin
          state_nxt = ON;
          phase_nxt = '0;
`ifdef LED_MATRIX_PWM_EN
          bright_nxt = brightness;
`endif
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      ON: begin
        if (phase == ROW_LAST) begin
          state_nxt = BLANK;
          phase_nxt = '0;
          row_nxt   = row + 1'b1;
          // Swapping only at the end of row 3 keeps front stable for a whole frame.
          if (row == 2'd3 && pending) begin
            front_nxt   = back;
            pending_nxt = 1'b0;
          end
        end else begin
          phase_nxt = phase + 1'b1;
        end
      end
      default: state_nxt = BLANK;
    endcase

    // frame_ready is low whenever a swap is possible, so accept and swap never collide.
    if (accept) begin
      back_nxt    = frm.frame_data;
      pending_nxt = 1'b1;
    end

`ifdef LED_MATRIX_PWM_EN
    lit = int'(phase_nxt) < int'(bright_nxt) * SLICE_CYCLES;
`endif

    // Outputs are computed from next state so the registered pins line up with the state.
    if (state_nxt == ON) begin
      aled_nxt = 4'(4'b0001 << row_nxt);
      if (lit) kled_nxt = front_nxt[{row_nxt, 2'b00} +: 4];
      frame_start_nxt = (state == BLANK) && (row == 2'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= BLANK;
      phase           <= '0;
      row             <= 2'd0;
      front           <= 16'h0000;
      back            <= 16'h0000;
      pending         <= 1'b0;
      aled            <= 4'b0000;
      kled_oe         <= 4'b0000;
      frame_start     <= 1'b0;
      frm.frame_ready <= 1'b1;
`ifdef LED_MATRIX_PWM_EN
      bright_lat      <= 4'd0;
`endif
    end else begin
      state           <= state_nxt;
      phase           <= phase_nxt;
      row             <= row_nxt;
      front           <= front_nxt;
      back            <= back_nxt;
      pending         <= pending_nxt;
      aled            <= aled_nxt;
      kled_oe         <= kled_nxt;
      frame_start     <= frame_start_nxt;
      frm.frame_ready <= !pending_nxt;
`ifdef LED_MATRIX_PWM_EN
      bright_lat      <= bright_nxt;
`endif
    end
  end
endmodule
